// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: depth/width helpers and common flag names.
// Imported by sync_fifo and sync_fifo_mem.
package fifo_pkg;

   // Number of storage entries for a given pointer size.
   function automatic int unsigned fifo_depth(input int unsigned ps);
      return 32'd1 << ps;
   endfunction

   // Pointers and the fill count carry one extra wrap bit above the address.
   function automatic int unsigned ptr_width(input int unsigned ps);
      return ps + 1;
   endfunction

   typedef enum logic [2:0] {
      FLAG_WFULL        = 3'd0,
      FLAG_REMPTY       = 3'd1,
      FLAG_ALMOST_FULL  = 3'd2,
      FLAG_ALMOST_EMPTY = 3'd3,
      FLAG_OVERFLOW     = 3'd4,
      FLAG_UNDERFLOW    = 3'd5
   } fifo_flag_e;

   localparam int unsigned FIFO_FLAG_COUNT = 6;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int dw = 8,
   parameter int ps = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [ps-1:0] waddr,
   input  logic [dw-1:0] wdata,
   input  logic [ps-1:0] raddr,
   output logic [dw-1:0] rdata
);

   localparam int unsigned DEPTH = fifo_depth(ps);

   logic [dw-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, almost thresholds, sticky over/underflow and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int dw    = 8,
   parameter int ps    = 4,
   parameter int af_th = 14,
   parameter int ae_th = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          winc,
   input  logic [dw-1:0] wdata,
   output logic          wfull,
   input  logic          rinc,
   output logic [dw-1:0] rdata,
   output logic          rempty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [ps:0]   count,
   output logic          overflow,
   output logic          underflow
);

   localparam int unsigned PW    = ptr_width(ps);
   localparam logic [ps:0] DEPTH = PW'(fifo_depth(ps));
   localparam logic [ps:0] AF    = PW'(af_th);
   localparam logic [ps:0] AE    = PW'(ae_th);
   localparam logic [ps:0] ONE   = PW'(1);

   logic [ps:0]   wptr, rptr;
   logic          wr_en, rd_en;
   logic [dw-1:0] mem_rdata;

   // Handshake: winc/rinc are requests. A transfer happens on the rising edge
   // when the request is high and the opposing flag (wfull for writes, rempty
   // for reads) is low in that same cycle; clr blocks both. A request against
   // an asserted flag is dropped and only sets the matching sticky flag.
   assign wr_en = winc && !wfull  && !clr;
   assign rd_en = rinc && !rempty && !clr;

   // Flags come straight from the registered pointers, so they move the cycle
   // after the accepted operation and clear instantly with rst_n.
   assign count        = wptr - rptr;
   assign wfull        = (count == DEPTH);
   assign rempty       = (count == '0);
   assign almost_full  = (count >= AF);
   assign almost_empty = (count <= AE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en) wptr <= wptr + ONE;
         if (rd_en) rptr <= rptr + ONE;
         if (winc && wfull)  overflow  <= 1'b1;
         if (rinc && rempty) underflow <= 1'b1;
      end
   end

   sync_fifo_mem #(
      .dw (dw),
      .ps (ps)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wptr[ps-1:0]),
      .wdata (wdata),
      .raddr (rptr[ps-1:0]),
      .rdata (mem_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   // Head of the queue is always presented; rinc acknowledges it.
   assign rdata = mem_rdata;
`else
   logic [dw-1:0] rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (clr) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= mem_rdata;
      end
   end

   assign rdata = rdata_q;
`endif

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO; same-domain successor to the dual-clock FIFO.
Adds fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and synchronous flush.
Sits between producer/consumer stages in one clock domain.
Keeps the `winc`/`rinc`/`wfull`/`rempty` handshake naming of the existing FIFO family.

Parameters:
dw, 8, data width in bits
ps, 4, pointer size; depth = 2**ps entries
af_th, 14, almost_full asserts when count >= af_th (1..2**ps)
ae_th, 2, almost_empty asserts when count <= ae_th (0..2**ps-1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush
winc  input  1  write request
wdata  input  dw  write data
wfull  output  1  FIFO full
rinc  input  1  read request
rdata  output  dw  read data
rempty  output  1  FIFO empty
almost_full  output  1  count >= af_th
almost_empty  output  1  count <= ae_th
count  output  ps+1  current fill level, 0..2**ps
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n=0, async): wptr=rptr=0, rdata=0, count=0, rempty=1, almost_empty=1, wfull=0, almost_full=0, overflow=0, underflow=0. Memory contents not reset.
- Pointers: ps+1-bit binary, MSB is wrap bit.
  - count = wptr - rptr (modulo 2**(ps+1)).
  - wfull = (count == 2**ps); rempty = (count == 0).
- Write accepted iff winc && !wfull: mem[wptr[ps-1:0]] <= wdata; wptr+1.
- Read accepted iff rinc && !rempty: rptr+1.
- Acceptance uses registered flags of the current cycle only.
  - Full with winc&rinc: read accepted, write dropped, overflow set; count = 2**ps-1 next cycle.
  - Empty with winc&rinc: write accepted, read dropped, underflow set; count = 1 next cycle.
  - Otherwise, simultaneous accepted write+read leaves count unchanged.
- All flags and count are registered/derived from registered pointers; they change the cycle after the accepted operation.
- Standard read mode:
  - rdata registered; shows popped entry one cycle after the accepted read (latency 1).
  - rdata holds its value when no read is accepted, including a rejected read.
- Wrap: pointers roll 2**(ps+1)-1 -> 0 with no gap; order is preserved across wrap.
- clr=1:
  - Next edge: wptr=rptr=0, overflow=underflow=0, rdata=0.
  - Overrides winc/rinc in the same cycle (no write, no read, no sticky set).
- Sticky flags clear only on clr or rst_n.
- Reset asserted mid-burst: outputs go to reset values immediately, without waiting for clk; in-flight operation discarded.

Optional Feature:
Macro `SYNC_FIFO_FWFT_EN` (first-word-fall-through).
- Defined:
  - rdata = mem[rptr[ps-1:0]] combinationally; valid whenever rempty=0.
  - rinc acknowledges/pops the word; rdata shows the next word in the same cycle the pointer advances.
  - After a write into an empty FIFO, rdata is valid the cycle rempty falls (1 cycle after the write).
  - rdata while empty is don't-care, not checked.
- Undefined: standard registered read, latency 1, as in Behaviour.
- Flag/count timing is identical in both builds.

Decomposition:
- Package `fifo_pkg`: depth function (2**ps), pointer/count width helper, shared flag-name constants for the FIFO family.
- Sub-module `sync_fifo_mem`:
  - Storage array only: 1 synchronous write port, 1 asynchronous read port, parametrised dw/ps.
  - Reused by the FWFT and standard paths.
- Control (pointers, flags, sticky bits, rdata register) stays in `sync_fifo`.

Test Plan:
All cases use dw=8, ps=4, af_th=14, ae_th=2.
1. Reset, then write 0..9 with rinc=0.
   -> rempty falls 1 cycle after first write; almost_empty falls when count becomes 3; count=10.
2. Write 0..15, then one more write of 0xAA.
   -> wfull=1 after 16th write; almost_full=1 at count 14; 0xAA dropped; overflow=1.
   -> Read 16: rdata sequence 0..15; rempty=1 at end.
3. Preload 5 words, then winc=rinc=1 for 20 cycles with wdata incrementing.
   -> count stays 5; pointers wrap; read order exactly matches write order.
4. Empty FIFO, rinc=1 for 1 cycle.
   -> underflow=1, count=0, rdata unchanged.
   -> Then clr=1: underflow=0.
5. count=7, then clr=1 with winc=1, wdata=0x55.
   -> Next cycle: count=0, rempty=1, the write is not stored.
   -> A later read after one write returns that later word, not 0x55.
6. rst_n driven low mid-burst between clock edges.
   -> count=0, rempty=1, rdata=0, sticky flags 0 immediately.
   -> Repeat 1–5 with `SYNC_FIFO_FWFT_EN` defined: rdata valid with rempty=0, zero read latency.
